ula_seq: RTL and testbench
==========================

ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width; SHALL be a power of two, 8..64.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  operand/opcode presented.
REQ-005 in_ready  out  1  block accepts operation this cycle.
REQ-006 A, B  in  WIDTH each  operands, two's complement.
REQ-007 opcode  in  5  operation select (REQ-012).
REQ-008 out_valid  out  1  result and flags valid.
REQ-009 out_ready  in  1  consumer takes result this cycle.
REQ-010 Out  out  WIDTH  registered result.
REQ-011 zero, negative, carry, overflow, illegal  out  1 each  registered flags, aligned with Out.

Function
REQ-012 Opcodes SHALL be: 00000 add A+B; 00001 addinc A+B+1; 00011 inca A+1; 00100 subdec A-B-1; 00101 sub A-B; 00110 deca A-1; 01000 lsl A<<1; 01001 asr A>>>1; 01010 lsln A<<B[log2 WIDTH-1:0]; 01011 asrn A>>>B[log2 WIDTH-1:0]; 01100 mul, low WIDTH bits of unsigned A*B; 10000 zeros; 10001 A&B; 10010 ~A&B; 10011 B; 10100 A&~B; 10101 A; 10110 A^B; 10111 A|B; 11000 ~A&~B; 11001 ~(A^B); 11010 ~A; 11011 ~A|B; 11100 ~B; 11101 A|~B; 11110 ~A|~B; 11111 all ones.
REQ-013 Any other opcode SHALL produce Out=0, illegal=1, other flags 0, with single-cycle latency.
REQ-014 Operation SHALL be accepted only on a cycle where in_valid and in_ready are both 1; A, B, opcode captured then.
REQ-015 FSM states IDLE, BUSY, DONE; IDLE->DONE on accept of non-mul op; IDLE->BUSY on accept of mul; BUSY->DONE after WIDTH iteration cycles; DONE->IDLE on out_ready without new accept; DONE->DONE or DONE->BUSY on out_ready with simultaneous accept.
REQ-016 in_ready SHALL be 1 in IDLE, and in DONE when out_ready is 1; 0 in BUSY.
REQ-017 Non-mul latency: out_valid SHALL rise the cycle after accept; mul: out_valid rises WIDTH+1 cycles after accept.
REQ-018 out_valid=1 only in DONE; Out and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Back-to-back: with out_ready held 1 and in_valid held 1, non-mul ops SHALL sustain one result per cycle.
REQ-020 zero = (Out==0); negative = Out[WIDTH-1], for all legal ops.
REQ-021 Add-class (add, addinc, inca): carry = bit WIDTH of the WIDTH+1-bit unsigned sum; overflow = signed overflow (operands same sign, result sign differs).
REQ-022 Sub-class (subdec, sub, deca): carry = 1 on unsigned borrow (A < B+dec, computed in WIDTH+1 bits); overflow = signed overflow of the subtraction.
REQ-023 Shifts: carry = last bit shifted out (0 when shift amount 0); overflow=0.
REQ-024 mul: overflow = 1 when upper WIDTH bits of 2*WIDTH-bit product are nonzero; carry=0.
REQ-025 Logic/constant ops: carry=0, overflow=0.
REQ-026 Out SHALL be a pure function of captured operands; no output updates in BUSY except iteration state.

Reset
REQ-027 With reset=1 at a clock edge: state=IDLE, out_valid=0, Out=0, all flags=0, multiplier state cleared; in_ready=1 from the first cycle after reset deasserts.
REQ-028 Reset in BUSY or DONE SHALL abort the operation; no result emitted; inputs ignored while reset=1.

Structure
REQ-029 Shared package ula_pkg SHALL hold opcode constants, FSM state enum and a flags struct {zero, negative, carry, overflow, illegal}.
REQ-030 Iterative shift-add multiplier SHALL be sub-module ula_mul_iter (start, done, WIDTH-cycle, 2*WIDTH-bit product); all other ops combinational in ula_seq, registered at DONE entry.

Verification
REQ-031 WIDTH=32, add A=0xFFFFFFFF, B=1 -> Out=0, zero=1, carry=1, overflow=0, out_valid one cycle after accept.
REQ-032 WIDTH=32, add A=0x7FFFFFFF, B=1 -> Out=0x80000000, negative=1, overflow=1, carry=0; sub A=3, B=5 -> Out=0xFFFFFFFE, carry=1, overflow=0.
REQ-033 WIDTH=32, mul A=0x10000, B=0x10000 -> out_valid at accept+33, Out=0, zero=1, overflow=1; in_ready=0 throughout BUSY.
REQ-034 Hold out_ready=0 for 5 cycles after result, then 1 with new in_valid -> Out stable for all 5 cycles, new op accepted on handover cycle, next result following cycle.
REQ-035 Assert reset 10 cycles into a mul -> out_valid never rises for it; next add 2+2 -> Out=4 one cycle after accept; opcode 00010 -> Out=0, illegal=1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and result flags.
package ula_pkg;

  localparam int unsigned OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD    = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_ADDINC = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_INCA   = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUBDEC = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_DECA   = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_LSL    = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_ASR    = 5'b01001;
  localparam logic [OPCODE_W-1:0] OP_LSLN   = 5'b01010;
  localparam logic [OPCODE_W-1:0] OP_ASRN   = 5'b01011;
  localparam logic [OPCODE_W-1:0] OP_MUL    = 5'b01100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/ula_mul_iter.sv
// Iterative shift-add unsigned multiplier: loads on start_i, product ready WIDTH cycles later.
module ula_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The load cycle folds in multiplier bit 0, so WIDTH-1 further steps finish the product.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start_i) begin
      acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a_i, 1'b0};
      mplier_d = b_i >> 1;
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU with valid/ready handshakes; combinational ops finish in one cycle,
// multiply goes through the iterative multiplier.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    A,
  input  logic [WIDTH-1:0]    B,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    Out,
  output logic                zero,
  output logic                negative,
  output logic                carry,
  output logic                overflow,
  output logic                illegal
);

  localparam int unsigned SW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  flags_t             flg_q, flg_d;

  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   add_y;
  logic               add_cin;
  logic [WIDTH:0]     add_sum;
  logic               add_ovf;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   lg_res;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flg;
  flags_t             mul_flg;

  ula_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock     (clock),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (A),
    .b_i       (B),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Add and subtract share one adder: subtraction is A + ~B + cin.
  always_comb begin
    add_y   = B;
    add_cin = 1'b0;
    case (opcode)
      OP_ADDINC: add_cin = 1'b1;
      OP_INCA: begin
        add_y   = '0;
        add_cin = 1'b1;
      end
      OP_SUBDEC: add_y = ~B;
      OP_SUB: begin
        add_y   = ~B;
        add_cin = 1'b1;
      end
      OP_DECA: add_y = '1;
      default: ;
    endcase
  end

  assign add_sum = {1'b0, A} + {1'b0, add_y} + (WIDTH+1)'(add_cin);
  assign add_ovf = (A[WIDTH-1] == add_y[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);

  // Shifts use one guard bit to capture the last bit shifted out.
  assign shamt   = ((opcode == OP_LSL) || (opcode == OP_ASR)) ? SW'(1) : B[SW-1:0];
  assign shl_ext = {1'b0, A} << shamt;
  assign shr_ext = $signed({A, 1'b0}) >>> shamt;

  // Logic opcodes carry their truth table in the low four bits.
  assign lg_res = ({WIDTH{opcode[0]}} &  A &  B) |
                  ({WIDTH{opcode[1]}} & ~A &  B) |
                  ({WIDTH{opcode[2]}} &  A & ~B) |
                  ({WIDTH{opcode[3]}} & ~A & ~B);

  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    case (opcode)
      OP_ADD, OP_ADDINC, OP_INCA: begin
        alu_res          = add_sum[WIDTH-1:0];
        alu_flg.carry    = add_sum[WIDTH];
        alu_flg.overflow = add_ovf;
      end
      OP_SUBDEC, OP_SUB, OP_DECA: begin
        alu_res          = add_sum[WIDTH-1:0];
        alu_flg.carry    = ~add_sum[WIDTH];
        alu_flg.overflow = add_ovf;
      end
      OP_LSL, OP_LSLN: begin
        alu_res       = shl_ext[WIDTH-1:0];
        alu_flg.carry = shl_ext[WIDTH];
      end
      OP_ASR, OP_ASRN: begin
        alu_res       = shr_ext[WIDTH:1];
        alu_flg.carry = shr_ext[0];
      end
      OP_MUL: ;
      default: begin
        if (opcode[4]) begin
          alu_res = lg_res;
        end else begin
          alu_flg.illegal = 1'b1;
        end
      end
    endcase
    alu_flg.zero     = (alu_res == '0) && !alu_flg.illegal;
    alu_flg.negative = alu_res[WIDTH-1];
  end

  always_comb begin
    mul_flg          = '0;
    mul_flg.zero     = (mul_prod[WIDTH-1:0] == '0);
    mul_flg.negative = mul_prod[WIDTH-1];
    mul_flg.overflow = |mul_prod[2*WIDTH-1:WIDTH];
  end

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    flg_d     = flg_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d   = ST_BUSY;
            mul_start = 1'b1;
          end else begin
            state_d = ST_DONE;
            res_d   = alu_res;
            flg_d   = alu_flg;
          end
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d = ST_DONE;
          res_d   = mul_prod[WIDTH-1:0];
          flg_d   = mul_flg;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_valid = (state_q == ST_DONE);
  assign Out       = res_q;
  assign zero      = flg_q.zero;
  assign negative  = flg_q.negative;
  assign carry     = flg_q.carry;
  assign overflow  = flg_q.overflow;
  assign illegal   = flg_q.illegal;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: directed vectors push expected results, a monitor checks them.
module tb_ula_seq;

  localparam int unsigned W = 32;
  localparam logic [4:0] FZ = 5'b10000;
  localparam logic [4:0] FN = 5'b01000;
  localparam logic [4:0] FC = 5'b00100;
  localparam logic [4:0] FV = 5'b00010;
  localparam logic [4:0] FI = 5'b00001;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [4:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  Out;
  logic          zero, negative, carry, overflow, illegal;

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic [4:0]  flg;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  bit          seen = 1'b0;

  ula_seq #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare the head entry every cycle out_valid is high, pop on handshake.
  initial forever begin
    @(negedge clock);
    #2;
    if (out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result out=%h flags=%b", Out,
                 {zero, negative, carry, overflow, illegal});
      end else begin
        if (!seen) begin
          seen = 1'b1;
          total++;
          if (cyc != sb[0].cyc) begin
            bad++;
            $display("FAIL %s_latency got cycle %0d want %0d", sb[0].nm, cyc, sb[0].cyc);
          end
        end
        total++;
        if (Out !== sb[0].res ||
            {zero, negative, carry, overflow, illegal} !== sb[0].flg) begin
          bad++;
          $display("FAIL %s got out=%h flags=%b want out=%h flags=%b", sb[0].nm, Out,
                   {zero, negative, carry, overflow, illegal}, sb[0].res, sb[0].flg);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eo, input logic [4:0] ef,
                       input bit rdy);
    exp_t e;
    int   n;
    @(negedge clock);
    out_ready = rdy;
    in_valid  = 1'b1;
    opcode    = op;
    A         = a;
    B         = b;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout in_ready=%b want 1", nm, in_ready);
      in_valid = 1'b0;
      return;
    end
    e.nm  = nm;
    e.res = eo;
    e.flg = ef;
    e.cyc = cyc + 1 + ((op == 5'b01100) ? W : 0);
    sb.push_back(e);
    @(posedge clock);
  endtask

  task automatic drain();
    int n;
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", sb.size());
    end
  endtask

  logic [31:0] lexp [16];
  logic [4:0]  lop;
  int          hits;

  initial begin
    lexp = '{32'h00000000, 32'hF000F000, 32'h0F000F00, 32'hFF00FF00,
             32'h00F000F0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0,
             32'h000F000F, 32'hF00FF00F, 32'h0F0F0F0F, 32'hFF0FFF0F,
             32'h00FF00FF, 32'hF0FFF0FF, 32'h0FFF0FFF, 32'hFFFFFFFF};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(Out), 64'd0);
    check("rst_flags", 64'({zero, negative, carry, overflow, illegal}), 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Arithmetic, back to back with out_ready held high.
    issue("add_wrap",  5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, FZ | FC, 1'b1);
    issue("add_ovf",   5'b00000, 32'h7FFFFFFF, 32'h1, 32'h80000000, FN | FV, 1'b1);
    issue("sub_neg",   5'b00101, 32'd3, 32'd5, 32'hFFFFFFFE, FN | FC, 1'b1);
    issue("addinc",    5'b00001, 32'd5, 32'd6, 32'd12, 5'b0, 1'b1);
    issue("inca_wrap", 5'b00011, 32'hFFFFFFFF, 32'h0, 32'h0, FZ | FC, 1'b1);
    issue("subdec",    5'b00100, 32'd10, 32'd3, 32'd6, 5'b0, 1'b1);
    issue("deca_zero", 5'b00110, 32'h0, 32'h0, 32'hFFFFFFFF, FN | FC, 1'b1);
    issue("deca_min",  5'b00110, 32'h80000000, 32'h0, 32'h7FFFFFFF, FV, 1'b1);
    issue("lsl",       5'b01000, 32'h80000001, 32'h0, 32'h00000002, FC, 1'b1);
    issue("asr",       5'b01001, 32'h80000001, 32'h0, 32'hC0000000, FN | FC, 1'b1);
    issue("lsln_28",   5'b01010, 32'h0000000F, 32'h1C, 32'hF0000000, FN, 1'b1);
    issue("lsln_hi_b", 5'b01010, 32'h1800000F, 32'hFFFFFFE4, 32'h800000F0, FN | FC, 1'b1);
    issue("asrn_31",   5'b01011, 32'h80000000, 32'd31, 32'hFFFFFFFF, FN, 1'b1);
    issue("asrn_0",    5'b01011, 32'h5, 32'h0, 32'h5, 5'b0, 1'b1);

    // All sixteen logic/constant opcodes in one burst.
    for (int k = 0; k < 16; k++) begin
      lop = 5'(16 + k);
      issue($sformatf("logic_%0d", k), lop, 32'hF0F0F0F0, 32'hFF00FF00, lexp[k],
            ((lexp[k] == 32'h0) ? FZ : 5'b0) | ((lexp[k] >= 32'h80000000) ? FN : 5'b0), 1'b1);
    end
    foreach (lexp[k]) begin end
    issue("illegal_02", 5'b00010, 32'h1234, 32'h5678, 32'h0, FI, 1'b1);
    issue("illegal_07", 5'b00111, 32'h1, 32'h1, 32'h0, FI, 1'b1);
    issue("illegal_0d", 5'b01101, 32'h1, 32'h1, 32'h0, FI, 1'b1);
    issue("illegal_0f", 5'b01111, 32'hFFFFFFFF, 32'h1, 32'h0, FI, 1'b1);
    drain();

    // Multiply: in_ready must stay low for every BUSY cycle.
    issue("mul_big", 5'b01100, 32'h10000, 32'h10000, 32'h0, FZ | FV, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < int'(W); i++) begin
      #1;
      if (in_ready) hits++;
      @(negedge clock);
    end
    check("mul_busy_in_ready", 64'(hits), 64'd0);
    drain();
    issue("mul_small", 5'b01100, 32'd3, 32'd7, 32'd21, 5'b0, 1'b1);
    issue("mul_ovf", 5'b01100, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, FN | FV, 1'b1);
    drain();

    // Hold the result for five cycles, then hand over to a new op on the same cycle.
    issue("hold_add", 5'b00000, 32'd1, 32'd1, 32'd2, 5'b0, 1'b0);
    hits = 0;
    do begin
      @(negedge clock);
      in_valid = 1'b0;
      #3;
      hits++;
    end while (!out_valid && hits < 50);
    check("hold_valid_seen", 64'(out_valid), 64'd1);
    repeat (4) @(negedge clock);
    issue("handover_sub", 5'b00101, 32'd9, 32'd4, 32'd5, 5'b0, 1'b1);
    drain();

    // Reset in the middle of a multiply drops it entirely.
    issue("mul_abort", 5'b01100, 32'd6, 32'd7, 32'd42, 5'b0, 1'b1);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    seen = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out", 64'(Out), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    hits = 0;
    repeat (W + 8) begin
      @(negedge clock);
      #1;
      if (out_valid) hits++;
    end
    check("abort_no_result", 64'(hits), 64'd0);
    issue("post_abort_add", 5'b00000, 32'd2, 32'd2, 32'd4, 5'b0, 1'b1);
    issue("post_abort_ill", 5'b00010, 32'd2, 32'd2, 32'h0, FI, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
